// File: rtl/adder_tb_pkg.sv
// Shared definitions for the adder regression checkers: run-state encoding,
// default sizes and the MISR seed.
package adder_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEFAULT           = 256;
  localparam int NUM_VECTORS_DEFAULT = 30000;
  localparam int MISR_SEED           = 0;

endpackage

// File: rtl/adder_response_checker_misr.sv
// Multiple-input signature register, polynomial x^w + 1: rotate left by one
// and fold in the new word whenever en is high.
module misr
  import adder_tb_pkg::*;
#(
  parameter int w = N_DEFAULT + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [w-1:0] d,
  output logic [w-1:0] sig
);

  logic [w-1:0] r_sig;

  // clr wins over en so a restart never folds a stale word into the new run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= w'(MISR_SEED);
    end else if (clr) begin
      r_sig <= w'(MISR_SEED);
    end else if (en) begin
      r_sig <= {r_sig[w-2:0], r_sig[w-1]} ^ d;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/adder_response_checker.sv
// Response-side checker for an adder under test: compares DUV against the
// reference per vector, counts, captures the first failure and signs the DUV outputs.
module adder_response_checker
  import adder_tb_pkg::*;
#(
  parameter int n           = N_DEFAULT,
  parameter int num_vectors = NUM_VECTORS_DEFAULT,
  parameter int cw          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          valid,
  input  logic          cin,
  input  logic [n-1:0]  a,
  input  logic [n-1:0]  b,
  input  logic [n-1:0]  s_ref,
  input  logic          cout_ref,
  input  logic [n-1:0]  s_duv,
  input  logic          cout_duv,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [cw-1:0] vec_count,
  output logic [cw-1:0] err_count,
  output logic [cw-1:0] first_fail_idx,
  output logic [n-1:0]  first_fail_a,
  output logic [n-1:0]  first_fail_b,
  output logic          first_fail_cin,
  output logic [n:0]    signature,
  output state_t        dbg_state
);

  // Handshake: valid has no ready partner. Every clk edge in RUN with valid=1
  // consumes exactly one settled vector; there is no backpressure.

  state_t        r_state;
  logic          r_pass;
  logic [cw-1:0] r_vec;
  logic [cw-1:0] r_err;
  logic [cw-1:0] r_ff_idx;
  logic [n-1:0]  r_ff_a;
  logic [n-1:0]  r_ff_b;
  logic          r_ff_cin;

  logic          w_accept;
  logic          w_mismatch;
  logic          w_last;
  logic          w_clr;
  logic [cw-1:0] w_vec_next;

  assign w_accept   = (r_state == RUN) && valid;
  assign w_mismatch = (s_duv != s_ref) || (cout_duv != cout_ref);
  assign w_vec_next = r_vec + cw'(1);
  assign w_last     = (w_vec_next == cw'(num_vectors));
  assign w_clr      = start && (r_state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pass   <= 1'b0;
      r_vec    <= '0;
      r_err    <= '0;
      r_ff_idx <= '0;
      r_ff_a   <= '0;
      r_ff_b   <= '0;
      r_ff_cin <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state  <= RUN;
            r_pass   <= 1'b0;
            r_vec    <= '0;
            r_err    <= '0;
            r_ff_idx <= '0;
            r_ff_a   <= '0;
            r_ff_b   <= '0;
            r_ff_cin <= 1'b0;
          end
        end
        RUN: begin
          if (valid) begin
            r_vec <= w_vec_next;
            if (w_mismatch && !(&r_err)) begin
              r_err <= r_err + cw'(1);
            end
            // err_count still zero means this is the first failure of the run
            if (w_mismatch && (r_err == '0)) begin
              r_ff_idx <= r_vec;
              r_ff_a   <= a;
              r_ff_b   <= b;
              r_ff_cin <= cin;
            end
            if (w_last) begin
              r_state <= DONE;
              r_pass  <= (r_err == '0) && !w_mismatch;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  misr #(
    .w(n + 1)
  ) u_misr (
    .clk(clk),
    .rst(rst),
    .clr(w_clr),
    .en (w_accept),
    .d  ({cout_duv, s_duv}),
    .sig(signature)
  );

  assign busy           = (r_state == RUN);
  assign done           = (r_state == DONE);
  assign pass           = r_pass;
  assign vec_count      = r_vec;
  assign err_count      = r_err;
  assign first_fail_idx = r_ff_idx;
  assign first_fail_a   = r_ff_a;
  assign first_fail_b   = r_ff_b;
  assign first_fail_cin = r_ff_cin;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_adder_response_checker.sv
// Bench for adder_response_checker: a 4-vector checker and a 1-vector checker
// share the applied vectors; run verdicts are predicted from the vector lists.
module tb_adder_response_checker;
  import adder_tb_pkg::*;

  localparam int N  = 8;
  localparam int NV = 4;
  localparam int CW = 32;
  localparam int RW = 1 + 3 * CW + 2 * N + 1 + (N + 1);

  // ---------------- clock / reset ----------------
  logic clk, rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic         start, start1, valid, cin, cout_ref, cout_duv;
  logic [N-1:0] a, b, s_ref, s_duv;

  logic          busy0, done0, pass0, ffc0;
  logic [CW-1:0] vec0, err0, idx0;
  logic [N-1:0]  ffa0, ffb0;
  logic [N:0]    sig0;
  state_t        st0;

  logic          busy1, done1, pass1, ffc1;
  logic [CW-1:0] vec1, err1, idx1;
  logic [N-1:0]  ffa1, ffb1;
  logic [N:0]    sig1;
  state_t        st1;

  adder_response_checker #(.n(N), .num_vectors(NV), .cw(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .cin(cin),
    .a(a), .b(b), .s_ref(s_ref), .cout_ref(cout_ref), .s_duv(s_duv), .cout_duv(cout_duv),
    .busy(busy0), .done(done0), .pass(pass0), .vec_count(vec0), .err_count(err0),
    .first_fail_idx(idx0), .first_fail_a(ffa0), .first_fail_b(ffb0),
    .first_fail_cin(ffc0), .signature(sig0), .dbg_state(st0)
  );

  adder_response_checker #(.n(N), .num_vectors(1), .cw(CW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .valid(valid), .cin(cin),
    .a(a), .b(b), .s_ref(s_ref), .cout_ref(cout_ref), .s_duv(s_duv), .cout_duv(cout_duv),
    .busy(busy1), .done(done1), .pass(pass1), .vec_count(vec1), .err_count(err1),
    .first_fail_idx(idx1), .first_fail_a(ffa1), .first_fail_b(ffb1),
    .first_fail_cin(ffc1), .signature(sig1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp1_q[$];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [RW-1:0] pack_res(input logic p, input logic [CW-1:0] v,
      input logic [CW-1:0] e, input logic [CW-1:0] i, input logic [N-1:0] fa,
      input logic [N-1:0] fb, input logic fc, input logic [N:0] s);
    return {p, v, e, i, fa, fb, fc, s};
  endfunction

  task automatic check_res(input string tag, input logic [RW-1:0] req, input logic [RW-1:0] act);
    cmp({tag, "_signature"}, act[8:0], req[8:0]);
    cmp({tag, "_ff_cin"},    act[9], req[9]);
    cmp({tag, "_ff_b"},      act[17:10], req[17:10]);
    cmp({tag, "_ff_a"},      act[25:18], req[25:18]);
    cmp({tag, "_ff_idx"},    act[57:26], req[57:26]);
    cmp({tag, "_err_count"}, act[89:58], req[89:58]);
    cmp({tag, "_vec_count"}, act[121:90], req[121:90]);
    cmp({tag, "_pass"},      act[122], req[122]);
  endtask

  // monitor: a rising done is the DUT presenting a verdict
  logic prev_done0 = 1'b0, prev_done1 = 1'b0;
  always @(negedge clk) begin
    if (done0 && !prev_done0) begin
      cmp("run_busy_low", busy0, 1'b0);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        check_res("run", exp_q.pop_front(),
                  pack_res(pass0, vec0, err0, idx0, ffa0, ffb0, ffc0, sig0));
      end
    end
    if (done1 && !prev_done1) begin
      if (exp1_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done1 actual=1 required=0");
      end else begin
        check_res("single", exp1_q.pop_front(),
                  pack_res(pass1, vec1, err1, idx1, ffa1, ffb1, ffc1, sig1));
      end
    end
    prev_done0 <= done0;
    prev_done1 <= done1;
  end

  // ---------------- vector tables and reference model ----------------
  logic [N-1:0] va[NV], vb[NV], vsr[NV], vsd[NV];
  logic         vc[NV], vcr[NV], vcd[NV];

  task automatic set_vec(input int k, input logic [N-1:0] ia, input logic [N-1:0] ib,
                         input logic ic, input logic id_c, input logic [N-1:0] id_s);
    int sum;
    sum = int'(ia) + int'(ib) + int'(ic);
    va[k] = ia; vb[k] = ib; vc[k] = ic;
    vsr[k] = N'(sum % 256); vcr[k] = (sum >= 256);
    vcd[k] = id_c; vsd[k] = id_s;
  endtask

  task automatic push_expect();
    int errs, first, sig, d;
    bit mm;
    errs = 0; first = -1; sig = 0;
    for (int k = 0; k < NV; k++) begin
      mm = (vsd[k] != vsr[k]) || (vcd[k] != vcr[k]);
      if (mm) begin
        if (first < 0) first = k;
        errs++;
      end
      d = int'({vcd[k], vsd[k]});
      sig = (((sig * 2) % 512) + (sig / 256)) ^ d;
    end
    if (first < 0)
      exp_q.push_back(pack_res(1'b1, NV, 0, 0, '0, '0, 1'b0, (N+1)'(sig)));
    else
      exp_q.push_back(pack_res(1'b0, NV, errs, first, va[first], vb[first], vc[first],
                               (N+1)'(sig)));
    mm = (vsd[0] != vsr[0]) || (vcd[0] != vcr[0]);
    if (mm) exp1_q.push_back(pack_res(1'b0, 1, 1, 0, va[0], vb[0], vc[0], {vcd[0], vsd[0]}));
    else    exp1_q.push_back(pack_res(1'b1, 1, 0, 0, '0, '0, 1'b0, {vcd[0], vsd[0]}));
  endtask

  // ---------------- driver ----------------
  task automatic junk();
    a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
    s_ref = N'($urandom); s_duv = N'($urandom);
    cout_ref = 1'($urandom); cout_duv = 1'($urandom);
  endtask

  task automatic drive_vec(input int k);
    valid = 1'b1; a = va[k]; b = vb[k]; cin = vc[k];
    s_ref = vsr[k]; cout_ref = vcr[k]; s_duv = vsd[k]; cout_duv = vcd[k];
  endtask

  task automatic do_run(input bit gaps, input bit mid_start, input bit sig_probe);
    int g, cyc;
    push_expect();
    @(negedge clk); start = 1'b1; start1 = 1'b1;
    @(negedge clk); start = 1'b0; start1 = 1'b0;
    for (int k = 0; k < NV; k++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      for (int j = 0; j < g; j++) begin
        valid = 1'b0; junk();
        start = mid_start;
        @(negedge clk);
      end
      start = 1'b0;
      drive_vec(k);
      @(negedge clk);
      cmp("vec_progress", vec0, k + 1);
      if (sig_probe && k == 0) cmp("sig_after_1ff", sig0, 9'h1FF);
      if (sig_probe && k == 1) cmp("sig_after_001", sig0, 9'h1FE);
    end
    valid = 1'b0; junk();
    cyc = 0;
    while (!done0 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    cmp("run_done", done0, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_busy"}, busy0, 1'b0);
    cmp({tag, "_done"}, done0, 1'b0);
    cmp({tag, "_pass"}, pass0, 1'b0);
    cmp({tag, "_vec"},  vec0, 0);
    cmp({tag, "_err"},  err0, 0);
    cmp({tag, "_idx"},  idx0, 0);
    cmp({tag, "_ffab"}, {ffa0, ffb0, ffc0}, 0);
    cmp({tag, "_sig"},  sig0, 0);
    cmp({tag, "_state"}, st0, IDLE);
    cmp({tag, "_done1"}, done1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N:0] r;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; valid = 1'b0; junk();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    valid = 1'b1;  // ignored while idle
    @(negedge clk);
    valid = 1'b0;
    check_zero("reset");

    // all matching
    for (int k = 0; k < NV; k++) set_vec(k, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10);
    do_run(1'b0, 1'b0, 1'b0);

    // vector 2 sum mismatch
    set_vec(2, 8'h05, 8'h0B, 1'b0, 1'b0, 8'h11);
    do_run(1'b0, 1'b0, 1'b0);

    // vectors 1 and 3 differ only in carry-out
    for (int k = 0; k < NV; k++) set_vec(k, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10);
    set_vec(1, 8'h21, 8'h33, 1'b1, 1'b1, 8'h55);
    set_vec(3, 8'h40, 8'h02, 1'b0, 1'b1, 8'h42);
    do_run(1'b0, 1'b0, 1'b0);

    // signature stepping: 1FF then 001
    set_vec(0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF);
    set_vec(1, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01);
    do_run(1'b0, 1'b0, 1'b1);

    // random vectors with gaps, start pulses mid-run, then identical rerun from DONE
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < NV; k++) begin
        set_vec(k, N'($urandom), N'($urandom), 1'($urandom), 1'b0, 8'h00);
        r = {vcr[k], vsr[k]};
        if ($urandom_range(0, 2) == 0) r = r ^ ((N+1)'(1) << $urandom_range(0, N));
        vcd[k] = r[N]; vsd[k] = r[N-1:0];
      end
      do_run(1'b1, 1'b1, 1'b0);
      do_run(1'b1, 1'b0, 1'b0);
    end

    // asynchronous reset after two vectors
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid = 1'b1; junk();
      @(negedge clk);
    end
    valid = 1'b0;
    cmp("pre_reset_vec", vec0, 2);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; junk();
      @(negedge clk);
    end
    valid = 1'b0;
    cmp("idle_vec", vec0, 0);
    cmp("idle_busy", busy0, 1'b0);
    cmp("idle_state", st0, IDLE);

    repeat (2) @(negedge clk);
    cmp("pending_runs", exp_q.size(), 0);
    cmp("pending_single", exp1_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
